mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 50 +++++
 rtl/mem_access_stage_load_align.sv | 30 +++
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 tb/tb_mem_access_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: reset and write
// polarities, bus widths, aluop codes, FSM state encoding and the layout of
// the stage's pipeline register.
package mem_access_stage_pkg;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 64;
    localparam int ALUOP_BUS_W      = 8;
    localparam int REG_ADDR_W       = 5;

    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_NOP   = 8'h00;
    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_MULT  = 8'h14;
    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_ADDIU = 8'h19;
    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LB    = 8'h90;
    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LW    = 8'h92;
    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_SB    = 8'h98;
    localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_SW    = 8'h9A;

    // IDLE must encode as zero so the debug state reads 0 during reset.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Execute-stage results held for the duration of one memory access.
    typedef struct packed {
        logic [ALUOP_BUS_W-1:0]      aluop;
        logic [REG_ADDR_W-1:0]       wa;
        logic                        wreg;
        logic                        whilo;
        logic                        mreg;
        logic [REG_BUS_W-1:0]        wd;
        logic [REG_BUS_W-1:0]        din;
        logic [DOUBLE_REG_BUS_W-1:0] mul;
    } mem_preg_t;

    function automatic logic is_mem_op(input logic [ALUOP_BUS_W-1:0] op);
        return (op == MINIMIPS32_LB) || (op == MINIMIPS32_LW) ||
               (op == MINIMIPS32_SB) || (op == MINIMIPS32_SW);
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_BUS_W-1:0] op);
        return (op == MINIMIPS32_SB) || (op == MINIMIPS32_SW);
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: LB picks one little-endian byte lane of the fetched
// word and sign-extends it; LW passes the word through unchanged.
module load_align
    import mem_access_stage_pkg::*;
(
    input  logic [REG_BUS_W-1:0] ld_data,
    input  logic [1:0]           byte_sel,
    input  logic                 is_byte,
    output logic [REG_BUS_W-1:0] result
);

    logic [7:0] lane;

    // Select the addressed byte lane, then sign-extend it for byte loads.
    always_comb begin
        lane = ld_data[7:0];
        case (byte_sel)
            2'd0:    lane = ld_data[7:0];
            2'd1:    lane = ld_data[15:8];
            2'd2:    lane = ld_data[23:16];
            default: lane = ld_data[31:24];
        endcase
        if (is_byte) begin
            result = {{24{lane[7]}}, lane};
        end else begin
            result = ld_data;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Holds execute results in a pipeline register,
// runs one data-bus transaction per load/store through a three-state FSM
// (IDLE/REQ/DONE), stalls upstream while the bus is busy, and presents the
// write-back and forwarding results.
//
// Data bus handshake: dbus_req is high for every REQ cycle and the request
// fields stay stable until the cycle in which dbus_ack is seen high; that
// cycle completes the access. dbus_ack outside REQ carries no meaning and is
// ignored. At most one request is outstanding; dbus_req drops in DONE.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                        cpu_clk_50M,
    input  logic                        cpu_rst_n,
    input  logic [ALUOP_BUS_W-1:0]      mem_aluop_i,
    input  logic [REG_ADDR_W-1:0]       mem_wa_i,
    input  logic                        mem_wreg_i,
    input  logic                        mem_whilo_i,
    input  logic                        mem_mreg_i,
    input  logic [REG_BUS_W-1:0]        mem_wd_i,
    input  logic [REG_BUS_W-1:0]        mem_din_i,
    input  logic [DOUBLE_REG_BUS_W-1:0] mem_mul_i,
    output logic                        stall_o,
    output logic                        dbus_req,
    output logic                        dbus_we,
    output logic [3:0]                  dbus_be,
    output logic [REG_BUS_W-1:0]        dbus_addr,
    output logic [REG_BUS_W-1:0]        dbus_wdata,
    input  logic                        dbus_ack,
    input  logic [REG_BUS_W-1:0]        dbus_rdata,
    output logic [REG_ADDR_W-1:0]       wb_wa_o,
    output logic                        wb_wreg_o,
    output logic [REG_BUS_W-1:0]        wb_wd_o,
    output logic                        wb_whilo_o,
    output logic [DOUBLE_REG_BUS_W-1:0] wb_hilo_o,
    output logic                        mem2id_wreg,
    output logic [REG_ADDR_W-1:0]       mem2id_wa,
    output logic [REG_BUS_W-1:0]        mem2id_wd,
    output logic                        mem2exe_whilo,
    output logic [DOUBLE_REG_BUS_W-1:0] mem2exe_hilo,
    output logic [1:0]                  dbg_state
);

    mem_state_t           state;
    mem_state_t           state_nxt;
    mem_preg_t            p;
    logic [REG_BUS_W-1:0] ld;
    logic [REG_BUS_W-1:0] ld_result;
    logic                 p_is_store;

    assign p_is_store = is_store_op(p.aluop);

    // Pipeline register: take new execute results whenever not stalled.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) begin
            p <= '0;
        end else if (!stall_o) begin
            p <= '{aluop: mem_aluop_i, wa: mem_wa_i, wreg: mem_wreg_i,
                   whilo: mem_whilo_i, mreg: mem_mreg_i, wd: mem_wd_i,
                   din: mem_din_i, mul: mem_mul_i};
        end
    end

    // Load data register: latch bus read data on the completing cycle.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) begin
            ld <= '0;
        end else if ((state == ST_REQ) && dbus_ack) begin
            ld <= dbus_rdata;
        end
    end

    // FSM state register; reset abandons any access in flight.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: wait in REQ for ack; otherwise follow the op being captured.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (dbus_ack) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = is_mem_op(mem_aluop_i) ? ST_REQ : ST_IDLE;
            end
        endcase
    end

    load_align u_load_align (
        .ld_data  (ld),
        .byte_sel (p.wd[1:0]),
        .is_byte  (p.aluop == MINIMIPS32_LB),
        .result   (ld_result)
    );

    // Outputs: bus request fields in REQ, write-back from P; all zero in reset.
    always_comb begin
        stall_o    = 1'b0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_be    = 4'b0000;
        dbus_addr  = '0;
        dbus_wdata = '0;
        wb_wa_o    = '0;
        wb_wreg_o  = 1'b0;
        wb_wd_o    = '0;
        wb_whilo_o = 1'b0;
        wb_hilo_o  = '0;
        dbg_state  = 2'b00;
        if (cpu_rst_n != RST_ENABLE) begin
            dbg_state = state;
            if (state == ST_REQ) begin
                stall_o   = 1'b1;
                dbus_req  = 1'b1;
                dbus_we   = p_is_store;
                dbus_addr = {p.wd[31:2], 2'b00};
                case (p.aluop)
                    MINIMIPS32_SB: begin
                        dbus_be    = 4'b0001 << p.wd[1:0];
                        dbus_wdata = {4{p.din[7:0]}};
                    end
                    MINIMIPS32_SW: begin
                        dbus_be    = 4'b1111;
                        dbus_wdata = p.din;
                    end
                    default: begin
                        dbus_be    = 4'b1111;
                        dbus_wdata = '0;
                    end
                endcase
            end
            wb_wa_o    = p.wa;
            wb_wd_o    = (p.mreg && (state == ST_DONE)) ? ld_result : p.wd;
            wb_whilo_o = p.whilo;
            wb_hilo_o  = p.mul;
            wb_wreg_o  = ((state == ST_REQ) || p_is_store) ? ~WRITE_ENABLE : p.wreg;
        end
    end

    assign mem2id_wreg   = wb_wreg_o;
    assign mem2id_wa     = wb_wa_o;
    assign mem2id_wd     = wb_wd_o;
    assign mem2exe_whilo = wb_whilo_o;
    assign mem2exe_hilo  = wb_hilo_o;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases, reset-in-flight, then a random
// instruction stream. Expected write-back tuples are queued as instructions
// are issued and popped when the stage presents its result.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int EXP_W = 1 + 5 + 32 + 1 + 64;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic [7:0]  mem_aluop_i = '0;
    logic [4:0]  mem_wa_i    = '0;
    logic        mem_wreg_i  = 1'b0;
    logic        mem_whilo_i = 1'b0;
    logic        mem_mreg_i  = 1'b0;
    logic [31:0] mem_wd_i    = '0;
    logic [31:0] mem_din_i   = '0;
    logic [63:0] mem_mul_i   = '0;
    logic        dbus_ack    = 1'b0;
    logic [31:0] dbus_rdata  = '0;

    logic        stall_o, dbus_req, dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [4:0]  wb_wa_o, mem2id_wa;
    logic        wb_wreg_o, wb_whilo_o, mem2id_wreg, mem2exe_whilo;
    logic [31:0] wb_wd_o, mem2id_wd;
    logic [63:0] wb_hilo_o, mem2exe_hilo;
    logic [1:0]  dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
        .mem_aluop_i(mem_aluop_i), .mem_wa_i(mem_wa_i), .mem_wreg_i(mem_wreg_i),
        .mem_whilo_i(mem_whilo_i), .mem_mreg_i(mem_mreg_i), .mem_wd_i(mem_wd_i),
        .mem_din_i(mem_din_i), .mem_mul_i(mem_mul_i),
        .stall_o(stall_o), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata),
        .wb_wa_o(wb_wa_o), .wb_wreg_o(wb_wreg_o), .wb_wd_o(wb_wd_o),
        .wb_whilo_o(wb_whilo_o), .wb_hilo_o(wb_hilo_o),
        .mem2id_wreg(mem2id_wreg), .mem2id_wa(mem2id_wa), .mem2id_wd(mem2id_wd),
        .mem2exe_whilo(mem2exe_whilo), .mem2exe_hilo(mem2exe_hilo),
        .dbg_state(dbg_state)
    );

    // Clock: 10 ns period.
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [1:0] k,
                                               input logic [31:0] word);
        logic [7:0] b;
        b = 8'(word >> (8 * k));
        if (op == MINIMIPS32_LB) return {{24{b[7]}}, b};
        return word;
    endfunction

    task automatic drive_bubble();
        mem_aluop_i = MINIMIPS32_NOP;
        mem_wa_i    = '0;
        mem_wreg_i  = 1'b0;
        mem_whilo_i = 1'b0;
        mem_mreg_i  = 1'b0;
        mem_wd_i    = '0;
        mem_din_i   = '0;
        mem_mul_i   = '0;
    endtask

    // Compare the presented write-back against the oldest expected tuple.
    task automatic scoreboard_pop(input string tag);
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] got;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 1, 0);
            return;
        end
        e   = exp_q.pop_front();
        got = {wb_wreg_o, wb_wa_o, wb_wd_o, wb_whilo_o, wb_hilo_o};
        check({tag, "_wb"}, got, e);
        check({tag, "_fwd"}, {mem2id_wreg, mem2id_wa, mem2id_wd, mem2exe_whilo, mem2exe_hilo}, e);
    endtask

    // Issue one instruction at a negedge; returns at the negedge its result is seen.
    task automatic issue(input string tag, input logic [7:0] op, input logic [4:0] wa,
                         input logic wreg, input logic whilo, input logic [31:0] wd,
                         input logic [31:0] din, input logic [63:0] mul,
                         input int waits, input logic [31:0] rdata);
        logic        is_ld, is_st;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        is_ld   = (op == MINIMIPS32_LB) || (op == MINIMIPS32_LW);
        is_st   = (op == MINIMIPS32_SB) || (op == MINIMIPS32_SW);
        e_wd    = is_ld ? model_load(op, wd[1:0], rdata) : wd;
        e_be    = 4'b1111;
        e_wdata = 32'h0;
        if (op == MINIMIPS32_SB) begin
            e_be    = (wd[1:0] == 2'd0) ? 4'b0001 : (wd[1:0] == 2'd1) ? 4'b0010 :
                      (wd[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
            e_wdata = {din[7:0], din[7:0], din[7:0], din[7:0]};
        end else if (op == MINIMIPS32_SW) begin
            e_wdata = din;
        end
        mem_aluop_i = op;
        mem_wa_i    = wa;
        mem_wreg_i  = wreg;
        mem_whilo_i = whilo;
        mem_mreg_i  = is_ld;
        mem_wd_i    = wd;
        mem_din_i   = din;
        mem_mul_i   = mul;
        exp_q.push_back({wreg & ~is_st, wa, e_wd, whilo, mul});
        @(posedge cpu_clk_50M);
        #1;
        drive_bubble();
        if (is_ld || is_st) begin
            for (int i = 1; i <= waits; i++) begin
                @(negedge cpu_clk_50M);
                check({tag, "_stall"}, stall_o, 1);
                check({tag, "_wreg_in_req"}, wb_wreg_o, 0);
                if (i == 1) begin
                    check({tag, "_req"}, dbus_req, 1);
                    check({tag, "_addr"}, dbus_addr, {wd[31:2], 2'b00});
                    check({tag, "_we"}, dbus_we, is_st);
                    check({tag, "_be"}, dbus_be, e_be);
                    check({tag, "_wdata"}, dbus_wdata, e_wdata);
                end
                if (i == waits) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rdata;
                end
                @(posedge cpu_clk_50M);
                #1;
                dbus_ack   = 1'b0;
                dbus_rdata = $urandom();
            end
        end
        @(negedge cpu_clk_50M);
        check({tag, "_stall_done"}, stall_o, 0);
        check({tag, "_req_done"}, dbus_req, 0);
        scoreboard_pop(tag);
    endtask

    initial begin
        logic [7:0] op_tab [7];
        logic [7:0] op;
        op_tab[0] = MINIMIPS32_NOP;  op_tab[1] = MINIMIPS32_ADDIU; op_tab[2] = MINIMIPS32_MULT;
        op_tab[3] = MINIMIPS32_LB;   op_tab[4] = MINIMIPS32_LW;    op_tab[5] = MINIMIPS32_SB;
        op_tab[6] = MINIMIPS32_SW;

        // Reset: outputs must be zero while reset is held, even with a load at the input.
        mem_aluop_i = MINIMIPS32_LW;
        mem_wd_i    = 32'h0000_0100;
        mem_wreg_i  = 1'b1;
        repeat (3) @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        check("rst_stall", stall_o, 0);
        check("rst_req", dbus_req, 0);
        check("rst_wb", {wb_wreg_o, wb_wa_o, wb_wd_o, wb_whilo_o, wb_hilo_o}, 0);
        check("rst_state", dbg_state, 0);
        drive_bubble();
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        check("idle_state", dbg_state, 0);

        // Directed cases.
        issue("addiu", MINIMIPS32_ADDIU, 5'd3, 1'b1, 1'b0, 32'h5, 32'h0, 64'h0, 0, 32'h0);
        issue("lw", MINIMIPS32_LW, 5'd4, 1'b1, 1'b0, 32'h100, 32'h0, 64'h0, 3, 32'hDEADBEEF);
        issue("lb3", MINIMIPS32_LB, 5'd5, 1'b1, 1'b0, 32'h203, 32'h0, 64'h0, 1, 32'h80112233);
        issue("lb1", MINIMIPS32_LB, 5'd6, 1'b1, 1'b0, 32'h201, 32'h0, 64'h0, 2, 32'h80112233);
        issue("sb", MINIMIPS32_SB, 5'd7, 1'b0, 1'b0, 32'h302, 32'hAB, 64'h0, 1, 32'h0);
        issue("sw", MINIMIPS32_SW, 5'd8, 1'b0, 1'b0, 32'h407, 32'h12345678, 64'h0, 2, 32'h0);
        issue("mult", MINIMIPS32_MULT, 5'd0, 1'b0, 1'b1, 32'h0, 32'h0, 64'h0000000100000002, 0, 32'h0);

        // Reset while a load is waiting for its ack; a later ack must be ignored.
        mem_aluop_i = MINIMIPS32_LW;
        mem_wa_i    = 5'd9;
        mem_wreg_i  = 1'b1;
        mem_mreg_i  = 1'b1;
        mem_wd_i    = 32'h500;
        @(posedge cpu_clk_50M);
        #1;
        drive_bubble();
        @(negedge cpu_clk_50M);
        check("rreq_req", dbus_req, 1);
        cpu_rst_n = 1'b0;
        #1;
        check("rreq_out_zero", {stall_o, dbus_req, wb_wreg_o, dbg_state}, 0);
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk_50M);
        check("rreq_req_after", dbus_req, 0);
        check("rreq_state", dbg_state, 0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hCAFEF00D;
        @(posedge cpu_clk_50M);
        #1;
        dbus_ack = 1'b0;
        @(negedge cpu_clk_50M);
        check("rreq_ack_ignored", dbg_state, 0);
        check("rreq_no_wb", {wb_wreg_o, wb_wd_o}, 0);

        // Random back-to-back stream.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            op = op_tab[$urandom_range(0, 6)];
            a  = $urandom();
            issue("rand", op, 5'($urandom_range(0, 31)),
                  (op != MINIMIPS32_NOP) && (op != MINIMIPS32_SB) && (op != MINIMIPS32_SW) &&
                  (op != MINIMIPS32_MULT),
                  op == MINIMIPS32_MULT, (op == MINIMIPS32_NOP) ? 32'h0 : a,
                  $urandom(), (op == MINIMIPS32_MULT) ? {$urandom(), $urandom()} : 64'h0,
                  $urandom_range(1, 4), $urandom());
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
